// File: rtl/usb_frame_sequencer.sv
// Frames a decimated sample stream into USB bytes: START, N samples (upper then lower half), STOP/status.
// Samples are buffered in a small FIFO; the byte port is a registered valid/ready interface.
module usb_frame_sequencer #(
  parameter int OW         = 16,
  parameter int USBDW      = 8,
  parameter int SAMPLES    = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter logic [USBDW-1:0] START_FLAG = 8'hFF,
  parameter logic [USBDW-1:0] STOP_FLAG  = 8'h8E
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             frame_start_i,
  input  logic [OW-1:0]    sample_i,
  input  logic             sample_valid_i,
  output logic [USBDW-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             overflow_o
);

  if (OW != 2*USBDW) begin : g_width_check
    $error("usb_frame_sequencer: OW must equal 2*USBDW");
  end

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLES + 1);
  localparam logic [CW-1:0] SAMPLES_C = CW'(SAMPLES);

  typedef enum logic [2:0] {IDLE, START, DATA_HI, DATA_LO, STOP} state_t;

  state_t state, state_d;

  logic [OW-1:0]    mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]    wr_cnt;
  logic [USBDW-1:0] lo_q, byte_d;
  logic             stop_sent;
  logic             empty, full, slot_free;
  logic             pop, push, wr_en, load, start_acc, stop_ld;
  logic [OW-1:0]    rd_data;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data   = mem[rd_ptr[AW-1:0]];
  assign slot_free = !valid_o || ready_i;
  assign busy_o    = (state != IDLE);

  // Samples are counted even when dropped so every frame ends after exactly SAMPLES strobes.
  assign wr_en = sample_valid_i && (state != IDLE) && (wr_cnt < SAMPLES_C);
  assign push  = wr_en && (!full || pop);

  always_comb begin
    state_d   = state;
    pop       = 1'b0;
    load      = 1'b0;
    byte_d    = '0;
    start_acc = 1'b0;
    stop_ld   = 1'b0;
    case (state)
      IDLE: if (frame_start_i && en_i) begin
        state_d   = START;
        start_acc = 1'b1;
      end
      START: if (slot_free) begin
        load    = 1'b1;
        byte_d  = START_FLAG;
        state_d = DATA_HI;
      end
      DATA_HI: begin
        if (slot_free && !empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          byte_d  = rd_data[OW-1:USBDW];
          state_d = DATA_LO;
        end else if (empty && (wr_cnt == SAMPLES_C)) begin
          state_d = STOP;
        end
      end
      DATA_LO: if (slot_free) begin
        load    = 1'b1;
        byte_d  = lo_q;
        state_d = DATA_HI;
      end
      STOP: begin
        if (!stop_sent && slot_free) begin
          load    = 1'b1;
          byte_d  = STOP_FLAG | {{(USBDW-1){1'b0}}, overflow_o};
          stop_ld = 1'b1;
        end else if (stop_sent && valid_o && ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      stop_sent <= 1'b0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      lo_q      <= '0;
    end else begin
      state     <= state_d;
      stop_sent <= (state_d == STOP) && (stop_sent || stop_ld);
      if (load) begin
        data_o  <= byte_d;
        valid_o <= 1'b1;
      end else if (slot_free) begin
        valid_o <= 1'b0;
      end
      if (pop) lo_q <= rd_data[USBDW-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_cnt     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (start_acc) begin
        wr_cnt     <= '0;
        overflow_o <= 1'b0;
      end else if (wr_en) begin
        wr_cnt <= wr_cnt + CW'(1);
        if (!push) overflow_o <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sample_i;
  end

endmodule

// File: tb/tb_usb_frame_sequencer.sv
// Scoreboard bench for usb_frame_sequencer: expected bytes queued at stimulus time, checked on accept.
module tb_usb_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        en_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic [15:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        busy_o;
  logic        overflow_o;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  int rmode = 1;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  usb_frame_sequencer #(
    .OW(16), .USBDW(8), .SAMPLES(4), .FIFO_DEPTH(2),
    .START_FLAG(8'hFF), .STOP_FLAG(8'h8E)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .frame_start_i(frame_start_i),
    .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // ready pattern: 0 = held low, 1 = held high, 2 = high one cycle in three
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rmode)
      0:       ready_i = 1'b0;
      1:       ready_i = 1'b1;
      default: ready_i = (cyc % 3 == 0);
    endcase
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      if (prev_stall) begin
        chk("stall_valid", valid_o, 1'b1);
        chk("stall_data", data_o, prev_data);
      end
      if (valid_o && ready_i) begin
        chk("q_avail", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) chk("byte", data_o, exp_q.pop_front());
        acc_cnt++;
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic en, input logic exp_ff);
    en_i = en;
    frame_start_i = 1'b1;
    if (exp_ff) exp_q.push_back(8'hFF);
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic keep);
    sample_i = d;
    sample_valid_i = 1'b1;
    if (keep) begin
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
    end
    tick();
    sample_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    tick(2);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_q", exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] pat [4];
    int base, n;
    pat[0] = 16'h1234; pat[1] = 16'h5678; pat[2] = 16'h9ABC; pat[3] = 16'hDEF0;

    #2 rst_i = 1'b1;
    tick(2);
    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    rst_i = 1'b0;
    tick(2);

    // basic frame, first sample also measures latency from an idle pipe
    start_frame(1'b1, 1'b1);
    tick(4);
    chk("pre_lat_valid", valid_o, 1'b0);
    send(pat[0], 1'b1);
    chk("lat_c1_valid", valid_o, 1'b0);
    tick();
    chk("lat_c2_valid", valid_o, 1'b1);
    chk("lat_c2_data", data_o, 8'h12);
    tick();
    chk("lat_c3_valid", valid_o, 1'b1);
    chk("lat_c3_data", data_o, 8'h34);
    for (int i = 1; i < 4; i++) begin
      tick(2);
      send(pat[i], 1'b1);
    end
    exp_q.push_back(8'h8E);
    wait_idle();
    chk("a_ovf", overflow_o, 1'b0);

    // throttled ready
    rmode = 2;
    start_frame(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(2);
      send(pat[i] ^ 16'h0F0F, 1'b1);
      tick(7);
    end
    exp_q.push_back(8'h8E);
    wait_idle();
    chk("b_ovf", overflow_o, 1'b0);

    // overflow: ready held low while samples arrive back to back
    rmode = 0;
    tick(3);
    start_frame(1'b1, 1'b1);
    tick();
    send(16'hA1B2, 1'b1);
    send(16'hC3D4, 1'b1);
    send(16'hE5F6, 1'b0);
    send(16'h0718, 1'b0);
    exp_q.push_back(8'h8F);
    tick(3);
    chk("c_ovf_mid", overflow_o, 1'b1);
    chk("c_busy_mid", busy_o, 1'b1);
    rmode = 1;
    wait_idle();
    chk("c_ovf_end", overflow_o, 1'b1);

    // disabled start is ignored and leaves the sticky flag alone
    start_frame(1'b0, 1'b0);
    send(16'h1111, 1'b0);
    tick();
    send(16'h2222, 1'b0);
    tick(5);
    chk("dis_valid", valid_o, 1'b0);
    chk("dis_busy", busy_o, 1'b0);
    chk("dis_ovf", overflow_o, 1'b1);

    // accepted start clears overflow; extra start mid-frame is ignored
    start_frame(1'b1, 1'b1);
    chk("d_ovf_clr", overflow_o, 1'b0);
    send(16'h3344, 1'b1);
    tick(2);
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(16'h5566 + 16'(i * 16'h1111), 1'b1);
      tick(2);
    end
    exp_q.push_back(8'h8E);
    wait_idle();

    // reset in mid-frame after the third data byte
    base = acc_cnt;
    start_frame(1'b1, 1'b1);
    send(16'h1234, 1'b1);
    tick();
    send(16'h5678, 1'b1);
    n = 0;
    while (acc_cnt - base < 4 && n < 200) begin
      tick();
      n++;
    end
    chk("rst_reach", (acc_cnt - base) >= 4, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", valid_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_ovf", overflow_o, 1'b0);
    exp_q.delete();
    tick();
    rst_i = 1'b0;
    tick(2);

    // clean frame after reset
    start_frame(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(2);
      send(pat[3 - i], 1'b1);
    end
    exp_q.push_back(8'h8E);
    wait_idle();
    chk("f_ovf", overflow_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
